// File: rtl/pattern_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : pattern_stim_gen
// Description : Sweeps a WIDTH-bit bus through binary, Gray, walking-one or
//               walking-zero patterns, holding each one for a programmable dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_stim_gen #(
    parameter int WIDTH   = 2,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               loop,
    output logic [WIDTH-1:0]   pattern,
    output logic               valid,
    output logic [WIDTH-1:0]   pat_idx,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   c_one       = WIDTH'(1);
    localparam logic [WIDTH-1:0]   c_all_ones  = '1;
    localparam logic [WIDTH-1:0]   c_walk_last = WIDTH'(WIDTH - 1);
    localparam logic [DWELL_W-1:0] c_dwell_one = DWELL_W'(1);

    function automatic logic [WIDTH-1:0] pat_of(input logic [1:0] m,
                                                input logic [WIDTH-1:0] i);
        case (m)
            2'd0:    pat_of = i;
            2'd1:    pat_of = i ^ (i >> 1);
            2'd2:    pat_of = c_one << i;
            default: pat_of = ~(c_one << i);
        endcase
    endfunction

    state_t             r_state, w_state;
    logic [1:0]         r_mode, w_mode;
    logic [DWELL_W-1:0] r_dwell, w_dwell;
    logic [DWELL_W-1:0] r_cnt, w_cnt;
    logic [WIDTH-1:0]   r_idx, w_idx;
    logic [WIDTH-1:0]   r_pattern, w_pattern;
    logic               r_valid, w_valid;
    logic               r_busy, w_busy;
    logic               r_done, w_done;

    logic [WIDTH-1:0]   w_last;
    logic               w_dwell_end;

    // Walking patterns (mode[1] set) end at WIDTH-1; counting patterns use the full index range.
    assign w_last      = r_mode[1] ? c_walk_last : c_all_ones;
    assign w_dwell_end = (r_cnt == r_dwell - c_dwell_one);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 2'd0;
            r_dwell   <= c_dwell_one;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_pattern <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_mode    <= w_mode;
            r_dwell   <= w_dwell;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_pattern <= w_pattern;
            r_valid   <= w_valid;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_mode    = r_mode;
        w_dwell   = r_dwell;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_pattern = r_pattern;
        w_valid   = r_valid;
        w_busy    = r_busy;
        w_done    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state   = S_RUN;
                    w_mode    = mode;
                    w_dwell   = (dwell == '0) ? c_dwell_one : dwell;
                    w_cnt     = '0;
                    w_idx     = '0;
                    w_pattern = pat_of(mode, '0);
                    w_valid   = 1'b1;
                    w_busy    = 1'b1;
                end
            end
            S_RUN: begin
                if (stop || (w_dwell_end && r_idx == w_last && !loop)) begin
                    w_state   = S_DONE;
                    w_cnt     = '0;
                    w_idx     = '0;
                    w_pattern = '0;
                    w_valid   = 1'b0;
                    w_done    = 1'b1;
                end else if (w_dwell_end) begin
                    // Index wraps to zero naturally at the last binary/Gray pattern.
                    w_idx     = (r_idx == w_last) ? '0 : r_idx + c_one;
                    w_pattern = pat_of(r_mode, w_idx);
                    w_cnt     = '0;
                end else begin
                    w_cnt = r_cnt + c_dwell_one;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign pattern = r_pattern;
    assign valid   = r_valid;
    assign pat_idx = r_idx;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pattern_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_stim_gen
// Description : Directed and randomized bench for pattern_stim_gen against a
//               time-based sweep model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_stim_gen;

    localparam int W  = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] dwell = '0;
    logic          loop = 1'b0;
    logic [W-1:0]  pattern;
    logic          valid;
    logic [W-1:0]  pat_idx;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    // Model: a sweep is a timeline of t cycles since start; index = t / D.
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_mode = 0;
    int m_d    = 1;
    int m_t    = 0;

    pattern_stim_gen #(.WIDTH(W), .DWELL_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .dwell   (dwell),
        .loop    (loop),
        .pattern (pattern),
        .valid   (valid),
        .pat_idx (pat_idx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int npat(input int md);
        return (md < 2) ? (1 << W) : W;
    endfunction

    function automatic logic [W-1:0] pat_of(input int md, input int i);
        logic [W-1:0] v;
        case (md)
            0:       v = W'(i);
            1:       v = W'(i ^ (i >> 1));
            2:       v = W'(1 << i);
            default: v = W'(~(1 << i));
        endcase
        return v;
    endfunction

    task automatic update_model();
        if (rst) begin
            m_run  = 1'b0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (!m_run) begin
            if (start) begin
                m_run  = 1'b1;
                m_mode = int'(mode);
                m_d    = (dwell == '0) ? 1 : int'(dwell);
                m_t    = 0;
            end
        end else if (stop) begin
            m_run  = 1'b0;
            m_done = 1'b1;
        end else begin
            m_t++;
            if (m_t == npat(m_mode) * m_d) begin
                if (loop) m_t = 0;
                else begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        int idx;
        idx = m_run ? (m_t / m_d) : 0;
        check_eq("pattern", 32'(pattern), m_run ? 32'(pat_of(m_mode, idx)) : 32'd0);
        check_eq("pat_idx", 32'(pat_idx), 32'(idx));
        check_eq("valid",   32'(valid),   32'(m_run));
        check_eq("busy",    32'(busy),    32'(m_run | m_done));
        check_eq("done",    32'(done),    32'(m_done));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            update_model();
            #1;
            compare_all();
        end
    endtask

    task automatic sweep(input logic [1:0] md, input logic [DW-1:0] dw, input int n);
        mode  = md;
        dwell = dw;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(n);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        tick(2);

        // Binary, dwell 10: eight patterns of ten cycles, then DONE and IDLE.
        sweep(2'd0, 8'd10, 82);
        // Gray, one pattern per cycle.
        sweep(2'd1, 8'd1, 10);
        // Walking-one, then walking-zero with dwell 0 behaving as 1.
        sweep(2'd2, 8'd1, 5);
        sweep(2'd3, 8'd0, 5);

        // Looping binary sweep; loop dropped during the second pass.
        loop = 1'b1;
        sweep(2'd0, 8'd2, 20);
        loop = 1'b0;
        tick(20);

        // Abort at edge 15, start ignored in DONE, restart at edge 17.
        sweep(2'd0, 8'd10, 14);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        start = 1'b1;
        tick(2);
        start = 1'b0;
        tick(10);

        // Reset mid-sweep, then a normal sweep.
        sweep(2'd1, 8'd3, 24);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        sweep(2'd2, 8'd2, 10);

        // Simultaneous start and stop in IDLE: start wins.
        stop = 1'b1;
        sweep(2'd0, 8'd1, 0);
        stop = 1'b0;
        tick(12);

        // Randomized traffic with input changes during active sweeps.
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            loop  = ($urandom_range(0, 3) != 0);
            mode  = 2'($urandom_range(0, 3));
            dwell = DW'($urandom_range(0, 4));
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pattern_stim_gen.md
Name: pattern_stim_gen

Overview:
Synthesizable, parametrised stimulus generator. It sweeps an N-bit output bus through a complete pattern set: binary count, Gray count, walking-one or walking-zero. Each pattern is held for a programmable number of clock cycles (its dwell time). It drives DUT inputs in self-checking benches and on-chip BIST, and replaces hand-written per-signal delay sequences.

Parameters:
WIDTH, 2, stimulus bus width; legal range 1..16.
DWELL_W, 16, width of the dwell-count input.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  begin a sweep; sampled only in IDLE.
stop  input  1  abort the sweep; sampled only in RUN.
mode  input  2  pattern set: 0 binary, 1 Gray, 2 walking-one, 3 walking-zero; latched at start.
dwell  input  DWELL_W  cycles each pattern is held; latched at start; 0 is treated as 1.
loop  input  1  1 = wrap to the first pattern after the last one instead of finishing; sampled at each wrap point.
pattern  output  WIDTH  current stimulus value, registered.
valid  output  1  pattern is a live stimulus value.
pat_idx  output  WIDTH  index of the current pattern, registered.
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse when a sweep completes or is aborted.

Behaviour:
- One clock and one reset only. Reset is synchronous and active-high. All outputs are registered.
- Reset values: pattern=0, pat_idx=0, valid=0, busy=0, done=0, state=IDLE, dwell counter=0, latched mode=0, latched dwell=1.
- Number of patterns, N: binary and Gray give 2^WIDTH; walking-one and walking-zero give WIDTH.
- Pattern function of index i:
  - binary: i
  - Gray: i ^ (i>>1)
  - walking-one: 1<<i
  - walking-zero: ~(1<<i), truncated to WIDTH
- Index and counter arithmetic is unsigned and wraps modulo its own width. No overflow is visible on any output.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - latch mode and dwell (D = max(dwell,1));
  - at edge k go to RUN with pat_idx=0, pattern=f(0), valid=1, busy=1, dwell counter=0.
- RUN: the dwell counter increments every cycle. When the counter = D-1:
  - if pat_idx < N-1: pat_idx increments, pattern=f(pat_idx+1), counter=0.
  - if pat_idx = N-1 and loop=1: pat_idx=0, pattern=f(0), counter=0. No done pulse is issued and the sweep continues.
  - if pat_idx = N-1 and loop=0: go to DONE with valid=0, pattern=0, pat_idx=0, done=1.
- Each pattern is therefore visible for exactly D cycles. First pattern latency from start is 0 cycles: it appears on the edge that samples start.
- stop=1 in RUN: takes priority over the dwell/advance logic on that edge. Go to DONE with valid=0, pattern=0, pat_idx=0, done=1.
- DONE lasts exactly one cycle: done=1, busy=1. The next edge goes to IDLE with done=0, busy=0.
- start in RUN or DONE is ignored and is not queued. start and stop both high in IDLE: start wins (stop is ignored in IDLE).
- mode, dwell and loop changes during RUN do not affect the active sweep. Exception: loop is re-sampled at every wrap point.
- rst during any state overrides all other inputs. It forces the reset values on that edge with no done pulse.
- WIDTH=1: walking-one yields the single pattern 1 (N=1); walking-zero yields the single pattern 0.

Test Plan:
- WIDTH=2, mode=0, dwell=10, start pulsed at edge 0 -> pattern 00 on edges 0-9, 01 on 10-19, 10 on 20-29, 11 on 30-39; done=1 and valid=0 at edge 40; busy=0 at edge 41.
- WIDTH=3, mode=1, dwell=1 -> one pattern per cycle in the order 000,001,011,010,110,111,101,100; a single done pulse follows the last pattern.
- WIDTH=4, mode=2, then a second sweep with mode=3, dwell=0 -> 0001,0010,0100,1000 at one cycle each (dwell 0 behaves as 1); the second sweep gives 1110,1101,1011,0111.
- WIDTH=2, mode=0, dwell=2, loop=1 held -> sequence 00,00,01,01,10,10,11,11,00,... with no done pulse. Drop loop to 0 during the second pass -> done is issued after the second 11.
- Abort and restart: stop asserted at edge 15 of a dwell=10 binary sweep -> pattern=0 and done=1 at edge 15. start re-pulsed during the DONE cycle is ignored. start pulsed at edge 17 begins a new sweep at 00.
- Reset mid-sweep: rst at edge 25 -> all outputs at reset values on edge 25 with no done pulse. start pulsed after rst is released -> the sweep runs normally.
